// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4
// Serial time-division demultiplexer. One serial line carries frames of four
// slots (channel 0..3), WIDTH bits per slot, MSB first. A frame-sync strobe
// marks the first bit of slot 0. The block hunts for sync, tracks bit and
// slot position, and loads each completed slot into its channel register
// with a one-cycle valid pulse. Sync violations produce a one-cycle error
// pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        bit-enable; din/fsync are only sampled on edges with en=1
//   din       serial data, MSB of each slot first
//   fsync     high on the bit that is slot 0, bit 0
//   ch0..ch3  last completed word of each channel (WIDTH bits each)
//   ch_valid  bit n pulses for one cycle when chn updates
//   locked    high while frame-aligned
//   sync_err  one-cycle pulse on any sync violation

module tdm_demux_1to4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             fsync,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic [3:0]       ch_valid,
   output logic             locked,
   output logic             sync_err
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   state_t             state;
   logic [CW-1:0]      bit_cnt;
   logic [1:0]         slot_cnt;
   logic [WIDTH-2:0]   shift;
   logic [WIDTH-1:0]   word_next;
   logic               frame_start;

   // The shift register only has to hold the WIDTH-1 bits already received;
   // the final bit of a slot comes straight from din, so the completed word
   // is always the stored bits with the current bit appended.
   always_comb begin
      word_next   = {shift, din};
      frame_start = (bit_cnt == '0) && (slot_cnt == 2'd0);
   end

   // Single sequential process: frame-alignment state machine, position
   // counters, shift register and all registered outputs. Pulses (ch_valid,
   // sync_err) are cleared on every edge, including edges with en=0, so they
   // last exactly one cycle. Everything else only moves on qualified bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HUNT;
         bit_cnt  <= '0;
         slot_cnt <= 2'd0;
         shift    <= '0;
         ch0      <= '0;
         ch1      <= '0;
         ch2      <= '0;
         ch3      <= '0;
         ch_valid <= 4'b0000;
         locked   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         ch_valid <= 4'b0000;
         sync_err <= 1'b0;
         if (en) begin
            unique case (state)
               HUNT: begin
                  // Bits without fsync are simply dropped while hunting.
                  if (fsync) begin
                     shift    <= word_next[WIDTH-2:0];
                     bit_cnt  <= CW'(1);
                     slot_cnt <= 2'd0;
                     locked   <= 1'b1;
                     state    <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (frame_start) begin
                     // A new frame must begin with fsync; without it the
                     // alignment is lost and this bit is thrown away.
                     if (fsync) begin
                        shift   <= word_next[WIDTH-2:0];
                        bit_cnt <= CW'(1);
                     end else begin
                        sync_err <= 1'b1;
                        locked   <= 1'b0;
                        state    <= HUNT;
                     end
                  end else if (fsync) begin
                     // fsync arriving mid-frame wins: the partial slot is
                     // abandoned and this bit restarts the frame at slot 0.
                     sync_err <= 1'b1;
                     shift    <= word_next[WIDTH-2:0];
                     bit_cnt  <= CW'(1);
                     slot_cnt <= 2'd0;
                  end else if (bit_cnt == LAST_BIT) begin
                     unique case (slot_cnt)
                        2'd0: ch0 <= word_next;
                        2'd1: ch1 <= word_next;
                        2'd2: ch2 <= word_next;
                        2'd3: ch3 <= word_next;
                     endcase
                     ch_valid <= 4'b0001 << slot_cnt;
                     bit_cnt  <= '0;
                     slot_cnt <= slot_cnt + 2'd1;
                  end else begin
                     shift   <= word_next[WIDTH-2:0];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4
// Directed bench for tdm_demux_1to4 (WIDTH=8). A single initial block walks
// through reset, a clean frame, an en-gapped frame, a missing fsync, an
// early fsync and an asynchronous reset in the middle of a slot, comparing
// outputs against hand-computed values with immediate assertions.

module tb_tdm_demux_1to4;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       din;
   logic       fsync;
   logic [7:0] ch0;
   logic [7:0] ch1;
   logic [7:0] ch2;
   logic [7:0] ch3;
   logic [3:0] ch_valid;
   logic       locked;
   logic       sync_err;

   int checks;
   int failures;

   tdm_demux_1to4 #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .din      (din),
      .fsync    (fsync),
      .ch0      (ch0),
      .ch1      (ch1),
      .ch2      (ch2),
      .ch3      (ch3),
      .ch_valid (ch_valid),
      .locked   (locked),
      .sync_err (sync_err)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one edge worth of inputs, then land 1 unit after the rising edge
   // so outputs are sampled well away from the active edge.
   task automatic applyStimulus(input logic e, input logic d, input logic f);
      begin
         en    = e;
         din   = d;
         fsync = f;
         @(posedge clk);
         #1;
      end
   endtask

   // One comparison point; counts every check and every failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      begin
         checks++;
         assert (observed === expected)
         else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         end
      end
   endtask

   // Send one 8-bit slot MSB first; fsync rides on the first bit when fs=1.
   // With gap=1 every qualified bit is preceded by an en=0 edge carrying
   // fsync=1 and junk data, which the design must ignore.
   task automatic sendSlot(input logic [7:0] w, input logic fs, input logic gap);
      begin
         for (int i = 7; i >= 0; i--) begin
            if (gap)
               applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'b1);
            applyStimulus(1'b1, w[i], (i == 7) ? fs : 1'b0);
         end
      end
   endtask

   logic [7:0] word;

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      din      = 1'b0;
      fsync    = 1'b0;

      // Reset held with random serial activity.
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      checkOutput("reset_ch0", 32'(ch0), 32'h00);
      checkOutput("reset_ch1", 32'(ch1), 32'h00);
      checkOutput("reset_ch2", 32'(ch2), 32'h00);
      checkOutput("reset_ch3", 32'(ch3), 32'h00);
      checkOutput("reset_valid", 32'(ch_valid), 32'h0);
      checkOutput("reset_locked", 32'(locked), 32'h0);
      checkOutput("reset_err", 32'(sync_err), 32'h0);
      rst_n = 1'b1;

      // Hunting: bits without fsync are ignored.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("hunt_locked", 32'(locked), 32'h0);
      checkOutput("hunt_valid", 32'(ch_valid), 32'h0);

      // Clean frame A5 3C 0F F0; lock on the first bit.
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("lock_edge1", 32'(locked), 32'h1);
      word = 8'hA5;
      for (int i = 6; i >= 0; i--)
         applyStimulus(1'b1, word[i], 1'b0);
      checkOutput("clean_ch0", 32'(ch0), 32'hA5);
      checkOutput("clean_v0", 32'(ch_valid), 32'h1);
      sendSlot(8'h3C, 1'b0, 1'b0);
      checkOutput("clean_ch1", 32'(ch1), 32'h3C);
      checkOutput("clean_v1", 32'(ch_valid), 32'h2);
      sendSlot(8'h0F, 1'b0, 1'b0);
      checkOutput("clean_ch2", 32'(ch2), 32'h0F);
      checkOutput("clean_v2", 32'(ch_valid), 32'h4);
      sendSlot(8'hF0, 1'b0, 1'b0);
      checkOutput("clean_ch3", 32'(ch3), 32'hF0);
      checkOutput("clean_v3", 32'(ch_valid), 32'h8);
      checkOutput("clean_err", 32'(sync_err), 32'h0);

      // Second frame starts on time; slot 0 = 5A.
      sendSlot(8'h5A, 1'b1, 1'b0);
      checkOutput("frame2_ch0", 32'(ch0), 32'h5A);
      checkOutput("frame2_v0", 32'(ch_valid), 32'h1);
      checkOutput("frame2_err", 32'(sync_err), 32'h0);
      checkOutput("frame2_locked", 32'(locked), 32'h1);

      // Remaining slots with en alternating (gap edges carry fsync=1).
      sendSlot(8'h3C, 1'b0, 1'b1);
      checkOutput("gap_ch1", 32'(ch1), 32'h3C);
      checkOutput("gap_v1", 32'(ch_valid), 32'h2);
      sendSlot(8'h0F, 1'b0, 1'b1);
      checkOutput("gap_ch2", 32'(ch2), 32'h0F);
      checkOutput("gap_v2", 32'(ch_valid), 32'h4);
      sendSlot(8'hF0, 1'b0, 1'b1);
      checkOutput("gap_ch3", 32'(ch3), 32'hF0);
      checkOutput("gap_v3", 32'(ch_valid), 32'h8);
      checkOutput("gap_err", 32'(sync_err), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("gap_pulse_end", 32'(ch_valid), 32'h0);
      checkOutput("gap_hold_ch3", 32'(ch3), 32'hF0);
      checkOutput("gap_hold_locked", 32'(locked), 32'h1);

      // Missing fsync at the frame boundary.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("miss_err", 32'(sync_err), 32'h1);
      checkOutput("miss_locked", 32'(locked), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("miss_err_pulse", 32'(sync_err), 32'h0);
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b1, 1'($urandom_range(1, 0)), 1'b0);
      checkOutput("miss_hunt", 32'(locked), 32'h0);
      checkOutput("miss_valid", 32'(ch_valid), 32'h0);
      checkOutput("miss_ch0", 32'(ch0), 32'h5A);
      checkOutput("miss_ch1", 32'(ch1), 32'h3C);
      checkOutput("miss_ch2", 32'(ch2), 32'h0F);
      checkOutput("miss_ch3", 32'(ch3), 32'hF0);

      // Relock, then fsync early at slot 1 bit 3.
      sendSlot(8'h11, 1'b1, 1'b0);
      checkOutput("relock_ch0", 32'(ch0), 32'h11);
      checkOutput("relock_v0", 32'(ch_valid), 32'h1);
      checkOutput("relock_locked", 32'(locked), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      word = 8'hC3;
      applyStimulus(1'b1, word[7], 1'b1);
      checkOutput("early_err", 32'(sync_err), 32'h1);
      checkOutput("early_locked", 32'(locked), 32'h1);
      checkOutput("early_valid", 32'(ch_valid), 32'h0);
      checkOutput("early_ch1", 32'(ch1), 32'h3C);
      for (int i = 6; i >= 1; i--)
         applyStimulus(1'b1, word[i], 1'b0);
      checkOutput("early_not_yet", 32'(ch_valid), 32'h0);
      applyStimulus(1'b1, word[0], 1'b0);
      checkOutput("early_ch0", 32'(ch0), 32'hC3);
      checkOutput("early_v0", 32'(ch_valid), 32'h1);
      checkOutput("early_err_clear", 32'(sync_err), 32'h0);

      // Slot 1 of the new frame, then reset part way through slot 2.
      sendSlot(8'h44, 1'b0, 1'b0);
      checkOutput("pre_rst_ch1", 32'(ch1), 32'h44);
      checkOutput("pre_rst_v1", 32'(ch_valid), 32'h2);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_ch0", 32'(ch0), 32'h00);
      checkOutput("arst_ch1", 32'(ch1), 32'h00);
      checkOutput("arst_ch3", 32'(ch3), 32'h00);
      checkOutput("arst_locked", 32'(locked), 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      rst_n = 1'b1;

      // Fresh frame after reset release.
      sendSlot(8'h11, 1'b1, 1'b0);
      checkOutput("post_ch0", 32'(ch0), 32'h11);
      checkOutput("post_v0", 32'(ch_valid), 32'h1);
      sendSlot(8'h22, 1'b0, 1'b0);
      checkOutput("post_ch1", 32'(ch1), 32'h22);
      checkOutput("post_v1", 32'(ch_valid), 32'h2);
      sendSlot(8'h33, 1'b0, 1'b0);
      checkOutput("post_ch2", 32'(ch2), 32'h33);
      checkOutput("post_v2", 32'(ch_valid), 32'h4);
      sendSlot(8'h44, 1'b0, 1'b0);
      checkOutput("post_ch3", 32'(ch3), 32'h44);
      checkOutput("post_v3", 32'(ch_valid), 32'h8);
      checkOutput("post_locked", 32'(locked), 32'h1);
      checkOutput("post_err", 32'(sync_err), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_pulse_end", 32'(ch_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
